// File: rtl/register_file.sv
// register_file: multi-ported general-purpose register file.
//
// Holds 2**ADDR_WIDTH registers of DATA_WIDTH bits. It has two
// combinational read ports and one synchronous write port. Register 0 is
// hard-wired to zero. An asynchronous active-low reset clears every register.
//
// Ports:
//   clk        - rising-edge clock for all register writes
//   rst_n      - asynchronous active-low reset; reads return 0 while it is low
//   read_reg1  - index for read port 1 (rs)
//   read_reg2  - index for read port 2 (rt)
//   write_reg  - index for the write port (rd/rt)
//   write_data - value to write
//   reg_write  - write enable
//   read_data1 - operand A, zero-latency read of register[read_reg1]
//   read_data2 - operand B, zero-latency read of register[read_reg2]
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, a read port that addresses the register
//                       being written in the current cycle returns write_data
//                       in that same cycle. When undefined, the port returns
//                       the stored value until the clock edge commits the write.

module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int unsigned NUM_REGS = 32'(1) << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_en_c;

    // A write takes effect only for a known-high enable and a non-zero index.
    // An X enable falls through to the hold path, so the stored state is kept.
    always_comb begin
        wr_en_c = 1'b0;
        if (reg_write && (write_reg != '0)) begin
            wr_en_c = 1'b1;
        end
    end

    // Next-state array: hold everything and overlay the single write.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en_c) begin
            regs_d[write_reg] = write_data;
        end
    end

    // Storage. Reset clears all registers at once, so a write that coincides
    // with reset is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: r0 and reset force zero; the optional bypass forwards the write.
    always_comb begin
        read_data1 = '0;
        if (rst_n && (read_reg1 != '0)) begin
            read_data1 = regs_q[read_reg1];
`ifdef REGFILE_BYPASS_EN
            if (wr_en_c && (read_reg1 == write_reg)) begin
                read_data1 = write_data;
            end
`endif
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        read_data2 = '0;
        if (rst_n && (read_reg2 != '0)) begin
            read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
            if (wr_en_c && (read_reg2 == write_reg)) begin
                read_data2 = write_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file. It runs directed scenarios and then random
// traffic. The expected values come from a plain array model of the register file.
module tb_register_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          reg_write;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;

    int n_tests;
    int n_fail;

    // Reference contents of the register file.
    logic [DW-1:0] model [NR];

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read value for the current inputs (model is the pre-edge state).
    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
        if (!rst_n || a == 0) return '0;
        if (BYPASS && reg_write && write_reg != 0 && write_reg == a) return write_data;
        return model[a];
    endfunction

    // Commit the current write to the model (called just before the rising edge).
    task automatic commit();
        if (rst_n && reg_write && write_reg != 0) model[write_reg] = write_data;
    endtask

    // Apply one set of inputs at the falling edge, check the reads, then let the edge pass.
    task automatic cycle(input string tag, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        reg_write = we; write_reg = wa; write_data = wd; read_reg1 = r1; read_reg2 = r2;
        #1;
        check({tag, "_rd1"}, read_data1, expect_rd(r1));
        check({tag, "_rd2"}, read_data2, expect_rd(r2));
        commit();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        rst_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;

        // Every index reads zero while reset is held.
        for (int i = 0; i < NR; i++) begin
            read_reg1 = AW'(i); read_reg2 = AW'(NR - 1 - i);
            #1;
            check("reset_rd1", read_data1, '0);
            check("reset_rd2", read_data2, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read, with both ports on the same register.
        cycle("wr8", 1'b1, 5'd8, 32'h12345678, 5'd8, 5'd8);
        cycle("rd8", 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        check("rd8_const", read_data1, 32'h12345678);

        // A write to r0 is ignored, both during the write cycle and after it.
        cycle("wr0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        check("wr0_now", read_data1, 32'h0);
        cycle("rd0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
        check("rd0_after", read_data1, 32'h0);

        // A disabled write leaves r3 untouched.
        cycle("wr3", 1'b1, 5'd3, 32'h00000007, 5'd3, 5'd0);
        cycle("nowr3", 1'b0, 5'd3, 32'hAAAA5555, 5'd3, 5'd3);
        cycle("rd3", 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        check("rd3_const", read_data1, 32'h00000007);

        // Same-cycle read of a register under write; the result depends on the build.
        cycle("wr9a", 1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
        cycle("wr9b", 1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
        check("byp9_const", read_data1, BYPASS ? 32'h2 : 32'h1);
        cycle("rd9", 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        check("rd9_const", read_data1, 32'h2);

        // Reset asserted in the middle of a cycle clears r5 without a clock edge.
        cycle("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        @(negedge clk);
        reg_write = 1'b0; read_reg1 = 5'd5; read_reg2 = 5'd8;
        #1;
        check("rd5_before_rst", read_data1, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        #1;
        check("rst5_rd1", read_data1, 32'h0);
        check("rst5_rd2", read_data2, 32'h0);

        // A write presented while reset is held is dropped.
        reg_write = 1'b1; write_reg = 5'd4; write_data = 32'h55; read_reg1 = 5'd4;
        @(posedge clk);
        #1;
        check("rst_wr4", read_data1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; reg_write = 1'b0;
        #1;
        check("post_rst_r4", read_data1, 32'h0);
        check("post_rst_r8", dut.read_data2, 32'h0);
        cycle("wr4", 1'b1, 5'd4, 32'h66, 5'd0, 5'd0);
        cycle("rd4", 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        check("rd4_const", read_data1, 32'h66);

        // Random traffic, biased toward read/write index collisions.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa, r1, r2;
            wa = AW'($urandom_range(0, NR - 1));
            r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
            r2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
            cycle("rand", 1'($urandom_range(0, 1)), wa, DW'($urandom), r1, r2);
        end

        // Final sweep of all registers against the model.
        for (int i = 0; i < NR; i++) begin
            cycle("sweep", 1'b0, 5'd0, 32'h0, AW'(i), AW'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
